// File: rtl/e_muldiv_pkg.sv
// Shared encodings and defaults for the E-stage multiply/divide unit.
package e_muldiv_pkg;

  localparam int unsigned DefWidth  = 32;
  localparam int unsigned DefMulLat = 5;

  localparam logic [3:0] OpNowrite = 4'd0;
  localparam logic [3:0] OpMult    = 4'd1;
  localparam logic [3:0] OpMultu   = 4'd2;
  localparam logic [3:0] OpDiv     = 4'd3;
  localparam logic [3:0] OpDivu    = 4'd4;
  localparam logic [3:0] OpMthi    = 4'd5;
  localparam logic [3:0] OpMtlo    = 4'd6;
  localparam logic [3:0] OpMfhi    = 4'd7;
  localparam logic [3:0] OpMflo    = 4'd8;
  localparam logic [3:0] OpMadd    = 4'd9;
  localparam logic [3:0] OpMaddu   = 4'd10;
  localparam logic [3:0] OpMsub    = 4'd11;
  localparam logic [3:0] OpMsubu   = 4'd12;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} hl_state_e;

  function automatic logic is_mul_op(logic [3:0] op);
    return op inside {OpMult, OpMultu, OpMadd, OpMaddu, OpMsub, OpMsubu};
  endfunction

  function automatic logic is_div_op(logic [3:0] op);
    return op inside {OpDiv, OpDivu};
  endfunction

  function automatic logic is_start_op(logic [3:0] op);
    return is_mul_op(op) || is_div_op(op);
  endfunction

endpackage

// File: rtl/e_div_iter.sv
// Unsigned radix-2 restoring divider: one quotient bit per iterate cycle, WIDTH cycles total.
module e_div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             iterate,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [WIDTH:0]   rem_sh, sub;
  logic             take;
  logic             unused_sub_msb;

  // Partial remainder stays below the divisor, so the difference always fits WIDTH bits.
  assign unused_sub_msb = sub[WIDTH];

  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    take   = rem_sh >= {1'b0, dvs_q};
    sub    = rem_sh - {1'b0, dvs_q};
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    if (start) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
    end else if (iterate) begin
      quo_d = {quo_q[WIDTH-2:0], take};
      rem_d = take ? sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/e_muldiv_iter.sv
// E-stage multiply/divide unit owning HI/LO: fixed-latency multiply with accumulate,
// iterative signed/unsigned divide, and flush cancellation of in-flight work.
module e_muldiv_iter
  import e_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned MUL_LAT = DefMulLat
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [3:0]       hl_op,
  input  logic             flush,
  output logic [WIDTH-1:0] hl_out,
  output logic             hl_busy,
  output logic             hl_done
);

  localparam int unsigned CntMax = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);
  localparam logic [CntW-1:0] CntMulLat = CntW'(MUL_LAT);
  localparam logic [CntW-1:0] CntWidth  = CntW'(WIDTH);

  hl_state_e          state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, rs_q;
  logic [2*WIDTH-1:0] mul_res_q;
  logic               q_neg_q, r_neg_q, div0_q, done_q;

  logic op_mul, op_div, op_start, op_signed, op_acc, op_sub;
  logic mul_issue, div_issue, div_iter, mul_commit, div_commit;

  always_comb begin
    op_mul    = is_mul_op(hl_op);
    op_div    = is_div_op(hl_op);
    op_start  = is_start_op(hl_op);
    op_signed = hl_op inside {OpMult, OpDiv, OpMadd, OpMsub};
    op_acc    = hl_op inside {OpMadd, OpMaddu, OpMsub, OpMsubu};
    op_sub    = hl_op inside {OpMsub, OpMsubu};
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!flush && op_mul)      state_d = StMul;
        else if (!flush && op_div) state_d = StDiv;
      end
      StMul:   if (flush || cnt_q == CntOne) state_d = StIdle;
      StDiv: begin
        if (flush)                state_d = StIdle;
        else if (cnt_q == CntOne) state_d = StFix;
      end
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: control outputs
  always_comb begin
    mul_issue  = 1'b0;
    div_issue  = 1'b0;
    div_iter   = 1'b0;
    mul_commit = 1'b0;
    div_commit = 1'b0;
    unique case (state_q)
      StIdle: begin
        mul_issue = !flush && op_mul;
        div_issue = !flush && op_div;
      end
      StMul:   mul_commit = !flush && (cnt_q == CntOne);
      StDiv:   div_iter   = !flush;
      StFix:   div_commit = !flush;
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (mul_issue)                                      cnt_d = CntMulLat;
    else if (div_issue)                                 cnt_d = CntWidth;
    else if (flush && state_q != StIdle)                cnt_d = '0;
    else if (state_q == StMul || state_q == StDiv)      cnt_d = cnt_q - CntOne;
  end

  // Multiply path: operands extended to 2*WIDTH so one unsigned multiply serves both signednesses.
  logic [2*WIDTH-1:0] a_ext, b_ext, prod, base, mul_res;
  always_comb begin
    a_ext   = op_signed ? {{WIDTH{rs[WIDTH-1]}}, rs} : {{WIDTH{1'b0}}, rs};
    b_ext   = op_signed ? {{WIDTH{rt[WIDTH-1]}}, rt} : {{WIDTH{1'b0}}, rt};
    prod    = a_ext * b_ext;
    base    = op_acc ? {hi_q, lo_q} : '0;
    mul_res = op_sub ? base - prod : base + prod;
  end

  // Divide path: magnitudes in, sign fix-up applied on commit.
  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag, div_quo, div_rem, quo_fix, rem_fix;
  always_comb begin
    rs_neg  = op_signed && rs[WIDTH-1];
    rt_neg  = op_signed && rt[WIDTH-1];
    rs_mag  = rs_neg ? -rs : rs;
    rt_mag  = rt_neg ? -rt : rt;
    quo_fix = q_neg_q ? -div_quo : div_quo;
    rem_fix = r_neg_q ? -div_rem : div_rem;
  end

  e_div_iter #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_issue),
    .iterate   (div_iter),
    .dividend  (rs_mag),
    .divisor   (rt_mag),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (mul_commit) begin
      {hi_d, lo_d} = mul_res_q;
    end else if (div_commit) begin
      hi_d = div0_q ? rs_q : rem_fix;
      lo_d = div0_q ? '1   : quo_fix;
    end else if (state_q == StIdle && !flush) begin
      if (hl_op == OpMthi) hi_d = rs;
      if (hl_op == OpMtlo) lo_d = rs;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      rs_q      <= '0;
      mul_res_q <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      div0_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= mul_commit || div_commit;
      if (mul_issue) mul_res_q <= mul_res;
      if (div_issue) begin
        q_neg_q <= rs_neg ^ rt_neg;
        r_neg_q <= rs_neg;
        div0_q  <= (rt == '0);
        rs_q    <= rs;
      end
    end
  end

  assign hl_busy = op_start || (state_q != StIdle);
  assign hl_done = done_q;
  assign hl_out  = (hl_op == OpMfhi) ? hi_q : (hl_op == OpMflo) ? lo_q : '0;

endmodule

// File: tb/tb_e_muldiv_iter.sv
// Directed self-checking bench for e_muldiv_iter (WIDTH=32, MUL_LAT=5).
module tb_e_muldiv_iter;

  localparam int W = 32;
  localparam int L = 5;

  localparam logic [3:0] NOWR = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
  localparam logic [3:0] MTHI = 4'd5, MTLO = 4'd6, MFHI = 4'd7, MFLO = 4'd8;
  localparam logic [3:0] MADD = 4'd9, MADDU = 4'd10, MSUBU = 4'd12;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] rs, rt, hl_out;
  logic [3:0]   hl_op;
  logic         flush, hl_busy, hl_done;

  int tests = 0;
  int fails = 0;

  e_muldiv_iter #(.WIDTH(W), .MUL_LAT(L)) dut (
    .clk     (clk),
    .reset   (reset),
    .rs      (rs),
    .rt      (rt),
    .hl_op   (hl_op),
    .flush   (flush),
    .hl_out  (hl_out),
    .hl_busy (hl_busy),
    .hl_done (hl_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_hilo(input string tag, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    hl_op = MFHI;
    #1 chk({tag, " HI"}, hl_out, ehi);
    hl_op = MFLO;
    #1 chk({tag, " LO"}, hl_out, elo);
    hl_op = NOWR;
  endtask

  task automatic write_hl(input logic [3:0] op, input logic [W-1:0] val);
    hl_op = op;
    rs    = val;
    tick();
    hl_op = NOWR;
  endtask

  // Issue in the current cycle, expect busy through c(nbusy), done in c(nbusy+1) (left there).
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int nbusy);
    int bad_busy = 0;
    int bad_done = 0;
    hl_op = op;
    rs    = a;
    rt    = b;
    #1 chk({tag, " busy c0"}, W'(hl_busy), W'(1));
    tick();
    hl_op = NOWR;
    for (int k = 1; k <= nbusy; k++) begin
      #1;
      if (hl_busy !== 1'b1) bad_busy++;
      if (hl_done !== 1'b0) bad_done++;
      tick();
    end
    chk({tag, " busy gaps"}, W'(bad_busy), W'(0));
    chk({tag, " early done"}, W'(bad_done), W'(0));
    #1;
    chk({tag, " busy after"}, W'(hl_busy), W'(0));
    chk({tag, " done pulse"}, W'(hl_done), W'(1));
  endtask

  initial begin
    int seen_done;
    reset = 1'b0;
    flush = 1'b0;
    hl_op = NOWR;
    rs    = '0;
    rt    = '0;
    #1;
    chk("reset busy", W'(hl_busy), W'(0));
    chk("reset done", W'(hl_done), W'(0));
    chk_hilo("reset", '0, '0);
    hl_op = MULT;
    #1 chk("reset busy decode", W'(hl_busy), W'(1));
    hl_op = NOWR;
    tick();
    reset = 1'b1;
    tick();

    run_op("mult", MULT, 32'hFFFF_FFFE, 32'd3, L);
    chk_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    tick();
    #1 chk("mult done one cycle", W'(hl_done), W'(0));

    run_op("divu", DIVU, 32'd100, 32'd7, W + 1);
    chk_hilo("divu", 32'd2, 32'd14);
    tick();
    run_op("div neg", DIV, 32'hFFFF_FFF9, 32'd2, W + 1);
    chk_hilo("div neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    tick();
    run_op("div negdvs", DIV, 32'd7, 32'hFFFF_FFFE, W + 1);
    chk_hilo("div negdvs", 32'd1, 32'hFFFF_FFFD);
    tick();
    run_op("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, W + 1);
    chk_hilo("div ovf", 32'd0, 32'h8000_0000);
    tick();
    run_op("div0", DIV, 32'd5, 32'd0, W + 1);
    chk_hilo("div0", 32'd5, 32'hFFFF_FFFF);
    tick();

    write_hl(MTLO, 32'hFFFF_FFFF);
    write_hl(MTHI, 32'd0);
    run_op("madd", MADD, 32'd1, 32'd1, L);
    chk_hilo("madd", 32'd1, 32'd0);
    // Back-to-back: next op issued in the done cycle.
    run_op("multu b2b", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, L);
    chk_hilo("multu b2b", 32'hFFFF_FFFE, 32'h0000_0001);
    tick();
    write_hl(MTHI, 32'd0);
    write_hl(MTLO, 32'd0);
    run_op("msubu", MSUBU, 32'd1, 32'd1, L);
    chk_hilo("msubu", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    run_op("maddu", MADDU, 32'hFFFF_FFFF, 32'd2, L);
    chk_hilo("maddu", 32'd1, 32'hFFFF_FFFD);
    tick();

    // Flush mid-divide; MTHI while busy must be ignored.
    write_hl(MTHI, 32'hAA);
    write_hl(MTLO, 32'h55);
    hl_op = DIVU;
    rs    = 32'd100;
    rt    = 32'd7;
    tick();
    hl_op = NOWR;
    for (int k = 1; k <= 9; k++) begin
      if (k == 5) begin
        hl_op = MTHI;
        rs    = 32'h1234;
        #1 chk("mthi busy", W'(hl_busy), W'(1));
      end
      tick();
      hl_op = NOWR;
    end
    flush = 1'b1;
    #1 chk("flush c10 busy", W'(hl_busy), W'(1));
    tick();
    flush = 1'b0;
    #1 chk("flush c11 busy", W'(hl_busy), W'(0));
    seen_done = 0;
    for (int k = 0; k < W + 4; k++) begin
      if (hl_done !== 1'b0) seen_done++;
      tick();
    end
    chk("flush no done", W'(seen_done), W'(0));
    chk_hilo("flush", 32'hAA, 32'h55);

    // Flush alongside an idle start op drops the op.
    hl_op = MULT;
    rs    = 32'd3;
    rt    = 32'd4;
    flush = 1'b1;
    #1 chk("flush start busy", W'(hl_busy), W'(1));
    tick();
    flush = 1'b0;
    hl_op = NOWR;
    #1 chk("dropped busy", W'(hl_busy), W'(0));
    seen_done = 0;
    for (int k = 0; k < L + 3; k++) begin
      if (hl_done !== 1'b0) seen_done++;
      tick();
    end
    chk("dropped no done", W'(seen_done), W'(0));
    chk_hilo("dropped", 32'hAA, 32'h55);

    // Asynchronous reset in the middle of a multiply.
    hl_op = MULT;
    rs    = 32'd3;
    rt    = 32'd4;
    tick();
    hl_op = NOWR;
    tick();
    #2 reset = 1'b0;
    #1 chk("async rst busy", W'(hl_busy), W'(0));
    chk("async rst done", W'(hl_done), W'(0));
    chk_hilo("async rst", '0, '0);
    tick();
    reset = 1'b1;
    seen_done = 0;
    for (int k = 0; k < L + 4; k++) begin
      #1;
      if (hl_done !== 1'b0 || hl_busy !== 1'b0) seen_done++;
      tick();
    end
    chk("post rst quiet", W'(seen_done), W'(0));
    chk_hilo("post rst", '0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
